// File: rtl/rs_dispatch_select.sv
// -----------------------------------------------------------------------------
// rs_dispatch_select
//
// Collapses per-reservation-station status back into encoded results for the
// issue logic and the functional unit (FU).
//   * Allocation: reports the lowest-index free station (combinational).
//   * Dispatch:   round-robin picks one operand-ready station, registers its
//                 opcode/operands/tag into a single output stage toward the FU
//                 (valid/ready handshake) and pulses a one-hot clear back to
//                 the winning station in the same cycle.
//
// Ports
//   clk, reset_n        clock (rising edge) and async active-low reset
//   flush               synchronous pipeline flush: empties the stage, ptr -> 0
//   rs_busy, rs_ready   per-station occupancy and operands-ready flags
//   rs_opcode/Vj/Vk/dest  per-station payload, station i at [i*W +: W]
//   alloc_valid/alloc_id  some station free / lowest free station id
//   grant_clear         one-hot clear pulse for the station being dispatched
//   fu_ready            FU accepts the output stage this cycle
//   fu_valid, fu_*      registered output stage, fu_rs_id = source station
// -----------------------------------------------------------------------------
module rs_dispatch_select #(
  parameter int NUM_RS     = 3,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 3,
  parameter int OP_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NUM_RS-1:0]            rs_busy,
  input  logic [NUM_RS-1:0]            rs_ready,
  input  logic [NUM_RS*OP_WIDTH-1:0]   rs_opcode,
  input  logic [NUM_RS*DATA_WIDTH-1:0] rs_Vj,
  input  logic [NUM_RS*DATA_WIDTH-1:0] rs_Vk,
  input  logic [NUM_RS*TAG_WIDTH-1:0]  rs_dest,
  output logic                         alloc_valid,
  output logic [2:0]                   alloc_id,
  output logic [NUM_RS-1:0]            grant_clear,
  input  logic                         fu_ready,
  output logic                         fu_valid,
  output logic [OP_WIDTH-1:0]          fu_opcode,
  output logic [DATA_WIDTH-1:0]        fu_Vj,
  output logic [DATA_WIDTH-1:0]        fu_Vk,
  output logic [TAG_WIDTH-1:0]         fu_dest,
  output logic [2:0]                   fu_rs_id
);

  localparam int                ID_W     = 3;
  localparam logic [ID_W:0]     NUM_RS_W = (ID_W+1)'(NUM_RS);
  localparam logic [NUM_RS-1:0] ONE_HOT0 = NUM_RS'(1);

  // ---------------------------------------------------------------------------
  // Allocation: lowest-index station whose busy bit is low.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    alloc_id = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!rs_busy[i]) alloc_id = ID_W'(i);
    end
  end

  assign alloc_valid = ~&rs_busy;

  // ---------------------------------------------------------------------------
  // Output-stage state
  // ---------------------------------------------------------------------------
  logic                  fu_valid_q,  fu_valid_d;
  logic [OP_WIDTH-1:0]   fu_opcode_q, fu_opcode_d;
  logic [DATA_WIDTH-1:0] fu_vj_q,     fu_vj_d;
  logic [DATA_WIDTH-1:0] fu_vk_q,     fu_vk_d;
  logic [TAG_WIDTH-1:0]  fu_dest_q,   fu_dest_d;
  logic [ID_W-1:0]       fu_rs_id_q,  fu_rs_id_d;
  logic [ID_W-1:0]       ptr_q,       ptr_d;

  // The stage can take a new entry when it is empty or draining this cycle.
  logic load_en;
  assign load_en = !flush && (!fu_valid_q || fu_ready);

  // ---------------------------------------------------------------------------
  // Round-robin search: rotate the eligible vector so the pointer lands on
  // bit 0, take the first set bit, then add the pointer back (mod NUM_RS).
  // ---------------------------------------------------------------------------
  logic [NUM_RS-1:0]   eligible;
  logic [2*NUM_RS-1:0] elig_dbl;
  logic [NUM_RS-1:0]   elig_rot;
  logic                found;
  logic [ID_W-1:0]     off;
  logic [ID_W:0]       win_sum, win_wrap, ptr_inc;
  logic [ID_W-1:0]     win, ptr_nxt;

  assign eligible = rs_ready & rs_busy;
  assign elig_dbl = {eligible, eligible} >> ptr_q;
  assign elig_rot = elig_dbl[NUM_RS-1:0];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < NUM_RS; j++) begin
      if (!found && elig_rot[j]) begin
        found = 1'b1;
        off   = ID_W'(j);
      end
    end
  end

  assign win_sum  = {1'b0, ptr_q} + {1'b0, off};
  assign win_wrap = win_sum - NUM_RS_W;
  assign win      = (win_sum >= NUM_RS_W) ? win_wrap[ID_W-1:0] : win_sum[ID_W-1:0];
  assign ptr_inc  = {1'b0, win} + (ID_W+1)'(1);
  assign ptr_nxt  = (ptr_inc >= NUM_RS_W) ? '0 : ptr_inc[ID_W-1:0];

  // Gated by reset_n so no station is cleared while the block is held in reset.
  assign grant_clear = (reset_n && load_en && found) ? (ONE_HOT0 << win) : '0;

  // Payload mux for the winning station.
  logic [OP_WIDTH-1:0]   op_sel;
  logic [DATA_WIDTH-1:0] vj_sel, vk_sel;
  logic [TAG_WIDTH-1:0]  dest_sel;

  always_comb begin
    op_sel   = '0;
    vj_sel   = '0;
    vk_sel   = '0;
    dest_sel = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (win == ID_W'(i)) begin
        op_sel   = rs_opcode[i*OP_WIDTH   +: OP_WIDTH];
        vj_sel   = rs_Vj    [i*DATA_WIDTH +: DATA_WIDTH];
        vk_sel   = rs_Vk    [i*DATA_WIDTH +: DATA_WIDTH];
        dest_sel = rs_dest  [i*TAG_WIDTH  +: TAG_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: hold by default (stall), flush empties the stage, a load
  // either captures the winner or empties the stage when nothing is eligible.
  // ---------------------------------------------------------------------------
  always_comb begin
    fu_valid_d  = fu_valid_q;
    fu_opcode_d = fu_opcode_q;
    fu_vj_d     = fu_vj_q;
    fu_vk_d     = fu_vk_q;
    fu_dest_d   = fu_dest_q;
    fu_rs_id_d  = fu_rs_id_q;
    ptr_d       = ptr_q;
    if (flush) begin
      fu_valid_d = 1'b0;
      ptr_d      = '0;
    end else if (load_en) begin
      if (found) begin
        fu_valid_d  = 1'b1;
        fu_opcode_d = op_sel;
        fu_vj_d     = vj_sel;
        fu_vk_d     = vk_sel;
        fu_dest_d   = dest_sel;
        fu_rs_id_d  = win;
        ptr_d       = ptr_nxt;
      end else begin
        fu_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fu_valid_q  <= 1'b0;
      fu_opcode_q <= '0;
      fu_vj_q     <= '0;
      fu_vk_q     <= '0;
      fu_dest_q   <= '0;
      fu_rs_id_q  <= '0;
      ptr_q       <= '0;
    end else begin
      fu_valid_q  <= fu_valid_d;
      fu_opcode_q <= fu_opcode_d;
      fu_vj_q     <= fu_vj_d;
      fu_vk_q     <= fu_vk_d;
      fu_dest_q   <= fu_dest_d;
      fu_rs_id_q  <= fu_rs_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign fu_valid  = fu_valid_q;
  assign fu_opcode = fu_opcode_q;
  assign fu_Vj     = fu_vj_q;
  assign fu_Vk     = fu_vk_q;
  assign fu_dest   = fu_dest_q;
  assign fu_rs_id  = fu_rs_id_q;

endmodule
